// File: rtl/data_mem_responder.sv
// Word-addressed data-memory responder: valid/ready request and response channels
// in front of a synchronous RAM, with programmable wait states and range check.
module data_mem_responder #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 16,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [15:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              busy
);

   // state  | meaning
   // IDLE   | ready for a request
   // WAIT   | wait states counting down
   // ACCESS | one-cycle array read/write
   // RESP   | response held until accepted
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WAIT   = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

   logic [1:0]        state;
   logic [3:0]        wait_cnt;
   logic              we_q;
   logic [15:0]       addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              in_range;
   logic              do_write;
   logic [ADDR_W-1:0] mem_idx;

   logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

   assign in_range = (addr_q[15:ADDR_W] == '0);
   assign mem_idx  = addr_q[ADDR_W-1:0];
   // Reset low at the ACCESS edge must suppress the store, so gate it here.
   assign do_write = rst && (state == S_ACCESS) && we_q && in_range;

   assign req_ready = (state == S_IDLE);
   assign rsp_valid = (state == S_RESP);
   assign busy      = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (do_write)
         mem[mem_idx] <= wdata_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         wait_cnt  <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  if (WAIT_CYCLES == 0) begin
                     state <= S_ACCESS;
                  end else begin
                     state    <= S_WAIT;
                     wait_cnt <= WAIT_LOAD;
                  end
               end
            end
            S_WAIT: begin
               if (wait_cnt == 4'd0)
                  state <= S_ACCESS;
               else
                  wait_cnt <= wait_cnt - 4'd1;
            end
            S_ACCESS: begin
               state <= S_RESP;
               if (!in_range) begin
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b1;
               end else begin
                  rsp_err   <= 1'b0;
                  rsp_rdata <= we_q ? '0 : mem[mem_idx];
               end
            end
            S_RESP: begin
               if (rsp_ready)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: three instances with 2, 0 and 5
// wait states, table-driven transactions checked through a response scoreboard.
module tb_data_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [2:0]  req_valid;
   logic [2:0]  req_we;
   logic [2:0]  rsp_ready;
   logic [15:0] req_addr  [3];
   logic [15:0] req_wdata [3];
   wire  [2:0]  req_ready;
   wire  [2:0]  rsp_valid;
   wire  [2:0]  rsp_err;
   wire  [2:0]  busy;
   wire  [15:0] rsp_rdata [3];

   data_mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(2)) u0 (
      .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
      .rsp_err(rsp_err[0]), .busy(busy[0]));

   data_mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(0)) u1 (
      .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
      .rsp_err(rsp_err[1]), .busy(busy[1]));

   data_mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(5)) u2 (
      .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
      .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
      .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]),
      .rsp_err(rsp_err[2]), .busy(busy[2]));

   typedef struct {
      logic [15:0] rdata;
      logic        err;
   } exp_t;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[13];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   acc_cyc [3];
   bit   tie [3];

   always @(posedge clk) cyc++;

   function automatic int wc(input int d);
      return (d == 0) ? 2 : (d == 1) ? 0 : 5;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic issue(input int d, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] er,
                        input logic ee, input bit push);
      int n = 0;
      exp_t e;
      @(negedge clk);
      while (!req_ready[d] && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready[d]) begin
         chk("req_ready_timeout", {31'd0, req_ready[d]}, 32'd1);
         return;
      end
      req_valid[d] = 1'b1;
      req_we[d]    = we;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      @(posedge clk);
      #1;
      acc_cyc[d]   = cyc;
      req_valid[d] = 1'b0;
      if (push) begin
         e.rdata = er;
         e.err   = ee;
         sb.push_back(e);
      end
   endtask

   task automatic wait_rsp(input int d, input int hold);
      int   n = 0;
      exp_t e;
      @(negedge clk);
      while (!rsp_valid[d] && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!rsp_valid[d]) begin
         chk("rsp_timeout", {31'd0, rsp_valid[d]}, 32'd1);
         return;
      end
      chk("latency", cyc - acc_cyc[d], wc(d) + 1);
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_rsp: got response on dut %0d with empty scoreboard", d);
         e.rdata = 16'h0;
         e.err   = 1'b0;
      end else begin
         e = sb.pop_front();
      end
      chk("rsp_rdata", rsp_rdata[d], e.rdata);
      chk("rsp_err", rsp_err[d], e.err);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         chk("bp_valid", rsp_valid[d], 1);
         chk("bp_rdata", rsp_rdata[d], e.rdata);
         chk("bp_req_ready", req_ready[d], 0);
      end
      rsp_ready[d] = 1'b1;
      @(posedge clk);
      #1;
      if (!tie[d]) rsp_ready[d] = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a1;
      int cnt;
      vecs[0]  = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0};
      vecs[1]  = '{1'b1, 16'h0005, 16'hA5A5, 16'h0000, 1'b0};
      vecs[2]  = '{1'b1, 16'h0020, 16'h1111, 16'h0000, 1'b0};
      vecs[3]  = '{1'b1, 16'h0030, 16'h3333, 16'h0000, 1'b0};
      vecs[4]  = '{1'b1, 16'h0012, 16'hBEEF, 16'h0000, 1'b0};
      vecs[5]  = '{1'b0, 16'h0012, 16'h0000, 16'hBEEF, 1'b0};
      vecs[6]  = '{1'b1, 16'h0100, 16'h1234, 16'h0000, 1'b1};
      vecs[7]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0};
      vecs[8]  = '{1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b1};
      vecs[9]  = '{1'b1, 16'hFF00, 16'h9999, 16'h0000, 1'b1};
      vecs[10] = '{1'b1, 16'h00FF, 16'h4242, 16'h0000, 1'b0};
      vecs[11] = '{1'b0, 16'h00FF, 16'h0000, 16'h4242, 1'b0};
      vecs[12] = '{1'b0, 16'h0020, 16'h0000, 16'h1111, 1'b0};

      rst       = 1'b0;
      req_valid = '0;
      req_we    = '0;
      rsp_ready = '0;
      for (int d = 0; d < 3; d++) begin
         req_addr[d]  = '0;
         req_wdata[d] = '0;
         tie[d]       = 1'b0;
         acc_cyc[d]   = 0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk("rst_req_ready", req_ready[d], 1);
         chk("rst_rsp_valid", rsp_valid[d], 0);
         chk("rst_rsp_rdata", rsp_rdata[d], 0);
         chk("rst_rsp_err", rsp_err[d], 0);
         chk("rst_busy", busy[d], 0);
      end
      rst = 1'b1;

      // Table: stores, loads, read-after-write and out-of-range accesses
      for (int i = 0; i < 13; i++) begin
         issue(0, vecs[i].we, vecs[i].addr, vecs[i].wdata,
               vecs[i].exp_rdata, vecs[i].exp_err, 1'b1);
         wait_rsp(0, 0);
      end

      // Response backpressure for four cycles
      issue(0, 1'b0, 16'h0005, 16'h0000, 16'hA5A5, 1'b0, 1'b1);
      wait_rsp(0, 4);
      @(negedge clk);
      chk("bp_idle_req_ready", req_ready[0], 1);
      chk("bp_idle_busy", busy[0], 0);
      chk("bp_idle_rsp_valid", rsp_valid[0], 0);

      // Request pulsed while busy must be ignored
      issue(0, 1'b0, 16'h0012, 16'h0000, 16'hBEEF, 1'b0, 1'b1);
      @(negedge clk);
      chk("busy_req_ready", req_ready[0], 0);
      chk("busy_flag", busy[0], 1);
      req_valid[0] = 1'b1;
      req_we[0]    = 1'b1;
      req_addr[0]  = 16'h0030;
      req_wdata[0] = 16'h7777;
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      req_we[0]    = 1'b0;
      wait_rsp(0, 0);
      cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (rsp_valid[0]) cnt++;
      end
      chk("busy_extra_rsp", cnt, 0);
      issue(0, 1'b0, 16'h0030, 16'h0000, 16'h3333, 1'b0, 1'b1);
      wait_rsp(0, 0);

      // Reset in early WAIT, at the WAIT exit edge, and at the ACCESS edge
      for (int dly = 0; dly < 3; dly++) begin
         issue(0, 1'b1, 16'h0020, 16'h5555, 16'h0000, 1'b0, 1'b0);
         repeat (dly + 1) @(negedge clk);
         rst = 1'b0;
         @(posedge clk);
         #1;
         rst = 1'b1;
         @(negedge clk);
         chk("mid_rst_rsp_valid", rsp_valid[0], 0);
         chk("mid_rst_req_ready", req_ready[0], 1);
         chk("mid_rst_busy", busy[0], 0);
         chk("mid_rst_rdata", rsp_rdata[0], 0);
         chk("mid_rst_err", rsp_err[0], 0);
         cnt = 0;
         repeat (8) begin
            @(negedge clk);
            if (rsp_valid[0]) cnt++;
         end
         chk("mid_rst_no_rsp", cnt, 0);
         issue(0, 1'b0, 16'h0020, 16'h0000, 16'h1111, 1'b0, 1'b1);
         wait_rsp(0, 0);
      end

      // Latency and back-to-back spacing with rsp_ready tied high
      for (int d = 1; d < 3; d++) begin
         tie[d]       = 1'b1;
         rsp_ready[d] = 1'b1;
         issue(d, 1'b1, 16'h0040, 16'hAAAA, 16'h0000, 1'b0, 1'b1);
         a1 = acc_cyc[d];
         wait_rsp(d, 0);
         issue(d, 1'b0, 16'h0040, 16'h0000, 16'hAAAA, 1'b0, 1'b1);
         chk("spacing", acc_cyc[d] - a1, wc(d) + 3);
         wait_rsp(d, 0);
         a1 = acc_cyc[d];
         issue(d, 1'b1, 16'h0140, 16'h5A5A, 16'h0000, 1'b1, 1'b1);
         chk("spacing_err", acc_cyc[d] - a1, wc(d) + 3);
         wait_rsp(d, 0);
      end

      chk("sb_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
